// File: rtl/mult_arb.sv
// mult_arb: round-robin arbiter sharing one sequential multiplier among NUM_REQ requesters
//   clk, rst                          clock, async active-high reset
//   req_i, req_mcand_i, req_mlier_i,
//   req_sgn_i                         per-requester request, packed operands, {mcand_sgn, mlier_sgn}
//   done_o, rsp_prod_o, rsp_err_o     one-hot completion pulse, captured product, watchdog error
//   m_start_o, m_clear_o, m_mcand_o,
//   m_mlier_o, m_mcand_sgn_o,
//   m_mlier_sgn_o                     multiplier control and operands
//   m_prod_i, m_busy_i                multiplier product and busy
module mult_arb #(
  parameter int NUM_REQ  = 2,
  parameter int BW_PTR   = 1,
  parameter int BW_MCAND = 3,
  parameter int BW_MLIER = 4,
  parameter int BW_TO    = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ*BW_MCAND-1:0]   req_mcand_i,
  input  logic [NUM_REQ*BW_MLIER-1:0]   req_mlier_i,
  input  logic [NUM_REQ*2-1:0]          req_sgn_i,
  output logic [NUM_REQ-1:0]            done_o,
  output logic [BW_MCAND+BW_MLIER-1:0]  rsp_prod_o,
  output logic                          rsp_err_o,
  output logic                          m_start_o,
  output logic                          m_clear_o,
  output logic [BW_MCAND-1:0]           m_mcand_o,
  output logic [BW_MLIER-1:0]           m_mlier_o,
  output logic                          m_mcand_sgn_o,
  output logic                          m_mlier_sgn_o,
  input  logic [BW_MCAND+BW_MLIER-1:0]  m_prod_i,
  input  logic                          m_busy_i
);
  localparam int PW = BW_MCAND + BW_MLIER;
  typedef enum logic [2:0] {INIT, IDLE, START, RUN, TOUT, DONE} state_t;
  state_t              state_q, state_d;
  logic [BW_PTR-1:0]   ptr_q, ptr_d, gnt_q, gnt_d, pick;
  logic [BW_TO-1:0]    to_q, to_d;
  logic [PW-1:0]       rsp_prod_q, rsp_prod_d;
  logic                rsp_err_q, rsp_err_d, found;
  logic [1:0]          sgn;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= INIT;
      ptr_q      <= '0;
      gnt_q      <= '0;
      to_q       <= '0;
      rsp_prod_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      to_q       <= to_d;
      rsp_prod_q <= rsp_prod_d;
      rsp_err_q  <= rsp_err_d;
    end
  end
  // scan requesters starting at ptr, wrapping, and take the first one set
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int s;
      logic [BW_PTR-1:0] idx;
      s = int'(ptr_q) + k;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      idx = BW_PTR'(s);
      if (!found && req_i[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gnt_d      = gnt_q;
    to_d       = to_q;
    rsp_prod_d = rsp_prod_q;
    rsp_err_d  = rsp_err_q;
    case (state_q)
      INIT: state_d = IDLE;
      IDLE: if (found) begin
        gnt_d   = pick;
        state_d = START;
      end
      START: begin
        to_d    = '0;
        state_d = RUN;
      end
      RUN: begin
        to_d = to_q + 1'b1;
        if (!m_busy_i) begin
          rsp_prod_d = m_prod_i;
          rsp_err_d  = 1'b0;
          state_d    = DONE;
        end else if (to_q == BW_TO'(BW_MLIER + 2)) begin
          rsp_prod_d = '0;
          rsp_err_d  = 1'b1;
          state_d    = TOUT;
        end
      end
      TOUT: state_d = DONE;
      DONE: begin
        ptr_d   = (gnt_q == BW_PTR'(NUM_REQ - 1)) ? '0 : gnt_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = INIT;
    endcase
  end
  assign sgn           = req_sgn_i[2*gnt_q +: 2];
  assign m_mcand_o     = req_mcand_i[gnt_q*BW_MCAND +: BW_MCAND];
  assign m_mlier_o     = req_mlier_i[gnt_q*BW_MLIER +: BW_MLIER];
  assign m_mcand_sgn_o = sgn[1];
  assign m_mlier_sgn_o = sgn[0];
  assign m_start_o     = state_q == START;
  assign m_clear_o     = state_q == INIT || state_q == TOUT;
  assign done_o        = (state_q == DONE) ? NUM_REQ'(1) << gnt_q : '0;
  assign rsp_prod_o    = rsp_prod_q;
  assign rsp_err_o     = rsp_err_q;
endmodule

// File: tb/tb_mult_arb.sv
// tb_mult_arb: directed self-checking bench for mult_arb with a behavioural multiplier
module tb_mult_arb;
  logic       clk = 1'b0, rst = 1'b1;
  logic [1:0] req = '0, done;
  logic [5:0] req_mcand = '0;
  logic [7:0] req_mlier = '0;
  logic [3:0] req_sgn = '0;
  logic [6:0] rsp_prod, m_prod;
  logic       rsp_err, m_start, m_clear, m_mcand_sgn, m_mlier_sgn, m_busy;
  logic [2:0] m_mcand;
  logic [3:0] m_mlier;
  logic       hang = 1'b0;
  logic [2:0] cnt;
  int checks = 0, errors = 0;
  mult_arb dut (
    .clk(clk), .rst(rst), .req_i(req), .req_mcand_i(req_mcand), .req_mlier_i(req_mlier),
    .req_sgn_i(req_sgn), .done_o(done), .rsp_prod_o(rsp_prod), .rsp_err_o(rsp_err),
    .m_start_o(m_start), .m_clear_o(m_clear), .m_mcand_o(m_mcand), .m_mlier_o(m_mlier),
    .m_mcand_sgn_o(m_mcand_sgn), .m_mlier_sgn_o(m_mlier_sgn), .m_prod_i(m_prod), .m_busy_i(m_busy)
  );
  always #5 clk = ~clk;
  // multiplier stand-in: busy for 4 cycles after start, product ready when busy falls
  always @(posedge clk) begin
    if (m_clear) begin
      cnt    <= '0;
      m_prod <= '0;
    end else if (m_start) begin
      cnt    <= 3'd4;
      m_prod <= (m_mcand_sgn ? {{4{m_mcand[2]}}, m_mcand} : {4'b0, m_mcand}) *
                (m_mlier_sgn ? {{3{m_mlier[3]}}, m_mlier} : {3'b0, m_mlier});
    end else if (cnt != 0) cnt <= cnt - 1'b1;
  end
  assign m_busy = hang || cnt != 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("init_clear", 32'(m_clear), 1);
    chk("init_done", 32'(done), 0);
    chk("init_prod", 32'(rsp_prod), 0);
    step();
    chk("idle_clear", 32'(m_clear), 0);
    repeat (3) begin
      step();
      chk("idle_done", 32'(done), 0);
      chk("idle_start", 32'(m_start), 0);
    end
    req_mcand = {3'b000, 3'b011};
    req_mlier = {4'b0000, 4'b0101};
    req = 2'b01;
    chk("t2_c0_start", 32'(m_start), 0);
    step();
    chk("t2_c1_start", 32'(m_start), 1);
    chk("t2_mcand", 32'(m_mcand), 3);
    chk("t2_mlier", 32'(m_mlier), 5);
    chk("t2_sgn", 32'({m_mcand_sgn, m_mlier_sgn}), 0);
    repeat (5) begin
      step();
      chk("t2_wait_done", 32'(done), 0);
    end
    step();
    chk("t2_done", 32'(done), 1);
    chk("t2_prod", 32'(rsp_prod), 15);
    chk("t2_err", 32'(rsp_err), 0);
    req = 2'b00;
    step();
    chk("t2_done_pulse", 32'(done), 0);
    chk("t2_prod_held", 32'(rsp_prod), 15);
    req_mcand = {3'b111, 3'b011};
    req_mlier = {4'b1110, 4'b0101};
    req_sgn = {2'b11, 2'b00};
    req = 2'b10;
    step();
    chk("t3_start", 32'(m_start), 1);
    chk("t3_mcand", 32'(m_mcand), 7);
    chk("t3_mlier", 32'(m_mlier), 14);
    chk("t3_sgn", 32'({m_mcand_sgn, m_mlier_sgn}), 3);
    repeat (5) begin
      step();
      chk("t3_wait_done", 32'(done), 0);
    end
    step();
    chk("t3_done", 32'(done), 2);
    chk("t3_prod", 32'(rsp_prod), 2);
    req = 2'b00;
    step();
    req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t4_start", 32'(m_start), 1);
      chk("t4_gnt_mcand", 32'(m_mcand), (k % 2 == 0) ? 3 : 7);
      repeat (5) begin
        step();
        chk("t4_wait_done", 32'(done), 0);
      end
      step();
      chk("t4_done", 32'(done), (k % 2 == 0) ? 1 : 2);
      chk("t4_prod", 32'(rsp_prod), (k % 2 == 0) ? 15 : 2);
      if (k == 3) req = 2'b00;
      step();
      chk("t4_idle_done", 32'(done), 0);
    end
    hang = 1'b1;
    req = 2'b01;
    step();
    chk("t5_start", 32'(m_start), 1);
    repeat (7) begin
      step();
      chk("t5_run_clear", 32'(m_clear), 0);
      chk("t5_run_done", 32'(done), 0);
    end
    step();
    chk("t5_tout_clear", 32'(m_clear), 1);
    chk("t5_tout_done", 32'(done), 0);
    step();
    chk("t5_done", 32'(done), 1);
    chk("t5_err", 32'(rsp_err), 1);
    chk("t5_prod", 32'(rsp_prod), 0);
    req = 2'b00;
    hang = 1'b0;
    step();
    chk("t5_idle_done", 32'(done), 0);
    req = 2'b10;
    step();
    chk("t6_start", 32'(m_start), 1);
    repeat (3) step();
    rst = 1'b1;
    #1;
    chk("t6_rst_clear", 32'(m_clear), 1);
    chk("t6_rst_done", 32'(done), 0);
    chk("t6_rst_prod", 32'(rsp_prod), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    chk("t6_init_clear", 32'(m_clear), 1);
    chk("t6_init_done", 32'(done), 0);
    step();
    chk("t6_idle_clear", 32'(m_clear), 0);
    step();
    chk("t6_start2", 32'(m_start), 1);
    chk("t6_mcand", 32'(m_mcand), 7);
    repeat (5) begin
      step();
      chk("t6_wait_done", 32'(done), 0);
    end
    step();
    chk("t6_done", 32'(done), 2);
    chk("t6_prod", 32'(rsp_prod), 2);
    chk("t6_err", 32'(rsp_err), 0);
    req = 2'b00;
    step();
    chk("t6_idle_done", 32'(done), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
